// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and sizing for the pipeline controller
package pipe_ctrl_pkg;
    typedef enum logic {RUN, MEM_WAIT} state_e;
    localparam int TIMEOUT_DEF = 255;
    localparam int REG_W = 5;
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard/status inputs and pipeline control outputs of pipe_ctrl
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
    logic id_rs1_used, id_rs2_used, ex_mem_read;
    logic m_mem_op, m_branch_taken, mem_ready, mem_req;
    logic pc_write, ifid_write, idex_write, exm_write, mwb_write;
    logic ifid_flush, idex_flush, exm_flush, mwb_flush;
    logic [31:0] stall_cycles;
    logic mem_err;
    modport master (
        input  id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, ex_mem_read,
        input  m_mem_op, m_branch_taken, mem_ready,
        output mem_req, pc_write, ifid_write, idex_write, exm_write, mwb_write,
        output ifid_flush, idex_flush, exm_flush, mwb_flush, stall_cycles, mem_err
    );
    modport slave (
        output id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, ex_mem_read,
        output m_mem_op, m_branch_taken, mem_ready,
        input  mem_req, pc_write, ifid_write, idex_write, exm_write, mwb_write,
        input  ifid_flush, idex_flush, exm_flush, mwb_flush, stall_cycles, mem_err
    );
endinterface

// File: rtl/pipe_ctrl_hazard_unit.sv
// hazard_unit: flags a load in EX whose destination feeds a source read in ID
module hazard_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);
    assign load_use = ex_mem_read && ex_rd != '0 &&
                      ((id_rs1_used && ex_rd == id_rs1) || (id_rs2_used && ex_rd == id_rs2));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with memory-wait timeout
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic        clk,
    input logic        reset,
    pipe_ctrl_if.master bus
);
    localparam int WW = $clog2(TIMEOUT + 1);
    state_e state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0] stall_q, stall_d;
    logic err_q, err_d;
    logic load_use, wait_st, to, hold, br, lu;
    hazard_unit u_hazard (
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_rs1_used(bus.id_rs1_used),
        .id_rs2_used(bus.id_rs2_used),
        .ex_mem_read(bus.ex_mem_read),
        .ex_rd      (bus.ex_rd),
        .load_use   (load_use)
    );
    // hold = memory stall; a timeout releases the wait exactly like mem_ready
    always_comb begin
        wait_st = state_q == MEM_WAIT;
        to      = wait_st && !bus.mem_ready && wait_q == WW'(TIMEOUT);
        hold    = !reset && !bus.mem_ready && (wait_st ? !to : bus.m_mem_op);
        br      = !reset && !wait_st && !hold && bus.m_branch_taken;
        lu      = !reset && !wait_st && !hold && !bus.m_branch_taken && load_use;
        state_d = hold ? MEM_WAIT : RUN;
        wait_d  = (wait_st && hold) ? wait_q + 1'b1 : '0;
        err_d   = err_q | to;
        stall_d = stall_q + 32'(hold || lu);
    end
    assign bus.pc_write     = !reset && !hold && !lu;
    assign bus.ifid_write   = !reset && !hold && !lu;
    assign bus.idex_write   = !reset && !hold;
    assign bus.exm_write    = !reset && !hold;
    assign bus.mwb_write    = !reset;
    assign bus.ifid_flush   = br;
    assign bus.idex_flush   = br || lu;
    assign bus.exm_flush    = br;
    assign bus.mwb_flush    = hold;
    assign bus.mem_req      = !reset && (wait_st || bus.m_mem_op);
    assign bus.stall_cycles = stall_q;
    assign bus.mem_err      = err_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl with TIMEOUT=8
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic reset;
    int vectors = 0;
    int miscompares = 0;
    pipe_ctrl_if pif ();
    pipe_ctrl #(.TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(pif));
    always #5 clk = ~clk;
    // {pc,ifid,idex,exm,mwb writes, ifid,idex,exm,mwb flushes, mem_req}
    localparam logic [9:0] IDLE  = 10'b11111_0000_0;
    localparam logic [9:0] IDLEM = 10'b11111_0000_1;
    localparam logic [9:0] LU    = 10'b00111_0100_0;
    localparam logic [9:0] BR    = 10'b11111_1110_0;
    localparam logic [9:0] MSTL  = 10'b00001_0001_1;
    localparam logic [9:0] RST   = 10'b00000_0000_0;
    function automatic logic [9:0] ctl();
        return {pif.pc_write, pif.ifid_write, pif.idex_write, pif.exm_write, pif.mwb_write,
                pif.ifid_flush, pif.idex_flush, pif.exm_flush, pif.mwb_flush, pif.mem_req};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                        input logic u2, input logic br, input logic mop, input logic rdy);
        @(negedge clk);
        reset = r;
        pif.ex_mem_read = mr;
        pif.ex_rd = rd;
        pif.id_rs1 = rs1;
        pif.id_rs1_used = u1;
        pif.id_rs2 = rs2;
        pif.id_rs2_used = u2;
        pif.m_branch_taken = br;
        pif.m_mem_op = mop;
        pif.mem_ready = rdy;
        #1;
    endtask
    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_ctl", 32'(ctl()), 32'(RST));
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("reset_memreq", 32'(ctl()), 32'(RST));
        chk("reset_stall", pif.stall_cycles, 0);
        chk("reset_err", 32'(pif.mem_err), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("idle", 32'(ctl()), 32'(IDLE));
        step(0, 1, 3, 3, 1, 0, 0, 0, 0, 0);
        chk("lu_rs1", 32'(ctl()), 32'(LU));
        step(0, 0, 3, 3, 1, 0, 0, 0, 0, 0);
        chk("lu_one_cycle", 32'(ctl()), 32'(IDLE));
        chk("lu_stall_cnt", pif.stall_cycles, 1);
        step(0, 1, 7, 3, 1, 7, 1, 0, 0, 0);
        chk("lu_rs2", 32'(ctl()), 32'(LU));
        step(0, 1, 7, 3, 1, 7, 0, 0, 0, 0);
        chk("rs2_unused", 32'(ctl()), 32'(IDLE));
        chk("lu_stall_cnt2", pif.stall_cycles, 2);
        step(0, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        chk("zero_reg", 32'(ctl()), 32'(IDLE));
        step(0, 1, 3, 3, 1, 0, 0, 1, 0, 0);
        chk("branch_over_lu", 32'(ctl()), 32'(BR));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("branch_no_stall", pif.stall_cycles, 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("mem_ready_hit", 32'(ctl()), 32'(IDLEM));
        step(0, 1, 3, 3, 1, 0, 0, 1, 1, 0);
        chk("mem_over_br_lu", 32'(ctl()), 32'(MSTL));
        step(0, 1, 3, 3, 1, 0, 0, 1, 1, 0);
        chk("wait_ignore_br", 32'(ctl()), 32'(MSTL));
        chk("wait_stall_cnt", pif.stall_cycles, 3);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wait_memreq", 32'(ctl()), 32'(MSTL));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("wait_4th", 32'(ctl()), 32'(MSTL));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("wait_release", 32'(ctl()), 32'(IDLEM));
        chk("mem_stall_cnt", pif.stall_cycles, 6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("back_to_run", 32'(ctl()), 32'(IDLE));
        chk("no_err", 32'(pif.mem_err), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("to_enter", 32'(ctl()), 32'(MSTL));
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("to_wait%0d", i), 32'(ctl()), 32'(MSTL));
            chk($sformatf("to_err_low%0d", i), 32'(pif.mem_err), 0);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_release", 32'(ctl()), 32'(IDLEM));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("to_run", 32'(ctl()), 32'(IDLE));
        chk("to_err_set", 32'(pif.mem_err), 1);
        chk("to_stall_cnt", pif.stall_cycles, 15);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("err_sticky", 32'(pif.mem_err), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rw_enter", 32'(ctl()), 32'(MSTL));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rw_wait1", 32'(ctl()), 32'(MSTL));
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rw_reset_ctl", 32'(ctl()), 32'(RST));
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rw_run", 32'(ctl()), 32'(IDLE));
        chk("rw_stall_clr", pif.stall_cycles, 0);
        chk("rw_err_clr", 32'(pif.mem_err), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Clock and reset SHALL be named clk and reset. There SHALL be one clock, and reset SHALL be synchronous and active-high.
REQ-002 Parameter TIMEOUT, default 255: the maximum number of MEM_WAIT cycles before a forced release.
REQ-003 clk  in  1  pipeline clock.
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 id_rs1, id_rs2  in  5 each  ID-stage source register indices.
REQ-006 id_rs1_used, id_rs2_used  in  1 each  ID instruction reads that source.
REQ-007 ex_mem_read  in  1  EX-stage instruction is a load.
REQ-008 ex_rd  in  5  EX-stage destination index.
REQ-009 m_mem_op  in  1  M-stage instruction is a load or store.
REQ-010 m_branch_taken  in  1  M-stage branch resolved taken (ALU zero qualified).
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 mem_req  out  1  data memory request.
REQ-013 pc_write, ifid_write, idex_write, exm_write, mwb_write  out  1 each  pipeline register write enables.
REQ-014 ifid_flush, idex_flush, exm_flush, mwb_flush  out  1 each  synchronous clear (bubble) of the pipeline register.
REQ-015 stall_cycles  out  32  count of cycles with pc_write=0.
REQ-016 mem_err  out  1  sticky memory-timeout flag.

Function
REQ-017 The FSM SHALL have exactly two states, RUN and MEM_WAIT. Write and flush outputs SHALL be combinational from state and inputs.
REQ-018 Default in RUN with no event: all writes 1, all flushes 0, mem_req=m_mem_op.
REQ-019 A load-use hazard SHALL be flagged when ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1 with id_rs1_used) or (ex_rd==id_rs2 with id_rs2_used).
REQ-020 Load-use response in RUN: pc_write=0, ifid_write=0, idex_flush=1, all other writes 1. The stall SHALL last exactly one cycle.
REQ-021 m_branch_taken in RUN: ifid_flush, idex_flush and exm_flush SHALL be 1, and all writes 1. A branch SHALL take priority over a simultaneous load-use hazard.
REQ-022 m_mem_op=1 with mem_ready=1 in RUN: no stall, state stays RUN.
REQ-023 m_mem_op=1 with mem_ready=0 in RUN: this cycle pc, ifid, idex and exm writes SHALL be 0 and mwb_flush=1, and the next state SHALL be MEM_WAIT. A memory stall SHALL take priority over load-use and branch.
REQ-024 In MEM_WAIT, mem_req SHALL be 1.
REQ-025 In MEM_WAIT with mem_ready=0: pc, ifid, idex and exm writes SHALL be 0 and mwb_flush=1, and the wait counter SHALL increment.
REQ-026 In MEM_WAIT with mem_ready=1: all writes 1, all flushes 0, and the next state SHALL be RUN.
REQ-027 When the wait counter reaches TIMEOUT in MEM_WAIT without mem_ready, the block SHALL set mem_err, release as in REQ-026, and return to RUN.
REQ-028 The wait counter SHALL clear on every entry to MEM_WAIT.
REQ-029 mem_err SHALL be sticky until reset.
REQ-030 stall_cycles SHALL increment on every non-reset cycle with pc_write=0 and SHALL wrap from 2^32-1 to 0.
REQ-031 Branch and load-use inputs SHALL be ignored while in MEM_WAIT.

Reset
REQ-032 While reset=1: all writes 0, all flushes 0, mem_req=0.
REQ-033 The next state after reset SHALL be RUN, with stall_cycles=0, wait counter=0 and mem_err=0.
REQ-034 Reset asserted during MEM_WAIT SHALL abort the wait with no mem_err set.

Structure
REQ-035 Package pipe_ctrl_pkg SHALL hold the state enumeration, the TIMEOUT default and the register-index width (5).
REQ-036 Load-use comparison SHALL be a combinational sub-module, hazard_unit.

Verification
REQ-037 Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3, id_rs1_used=1 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_cycles increments by 1.
REQ-038 Branch plus hazard: conditions of REQ-037 with m_branch_taken=1 -> ifid_flush, idex_flush, exm_flush=1; pc_write=1; no stall counted.
REQ-039 Memory wait: m_mem_op=1, mem_ready low 4 cycles then high -> 4 stall cycles, then RUN; stall_cycles=4; mwb_flush=1 for those 4 cycles.
REQ-040 Timeout: TIMEOUT=8, mem_ready held 0 -> mem_err=1 after 8 wait cycles, writes released, mem_err holds until reset.
REQ-041 Reset mid-wait: reset at the 2nd MEM_WAIT cycle -> state RUN, stall_cycles=0, mem_err=0, mem_req=0 during reset.
REQ-042 Zero register: ex_rd=0 with matching id_rs1 -> no stall.
